// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for lock, qualifies
// lock stability, then flags the clocks ready; retries a bounded number of times.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRY     = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       force_rst,
  output logic       pll_rst,
  output logic       clk_ready,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic       lock_lost,
  output logic [2:0] state
);

  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  // SETTLE spans STABLE_CYCLES+1 cycles so clk_ready rises STABLE_CYCLES+1
  // edges after lock is first seen in WAIT.
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES);
  localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_ASSERT = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  function automatic logic state_parity(input state_t s);
    return ^s;
  endfunction

  logic [1:0]    sync_r;
  logic          locked_s;
  state_t        state_r;
  state_t        state_nxt_s;
  logic          state_par_r;
  logic          state_err_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic [1:0]    retry_r;
  logic [1:0]    retry_nxt_s;
  logic          retry_full_s;
  logic          lock_lost_nxt_s;
  logic          pll_rst_r;
  logic          clk_ready_r;
  logic          fail_r;
  logic          lock_lost_r;

  assign locked_s     = sync_r[1];
  assign state_err_s  = state_par_r ^ state_parity(state_r);
  assign retry_full_s = (retry_r == RETRY_MAX);

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], pll_locked};
    end
  end

  // Next-state, shared counter and retry bookkeeping.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    retry_nxt_s     = retry_r;
    lock_lost_nxt_s = 1'b0;
    if (force_rst) begin
      state_nxt_s = ST_ASSERT;
      cnt_nxt_s   = CNT_ZERO;
      retry_nxt_s = 2'd0;
    end else if (state_err_s) begin
      // A corrupted state register restarts the sequence with the PLL in reset.
      state_nxt_s = ST_ASSERT;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_ASSERT: begin
          if (cnt_r == RST_LAST) begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_WAIT: begin
          if (locked_s) begin
            state_nxt_s = ST_SETTLE;
            cnt_nxt_s   = CNT_ZERO;
          end else if (cnt_r == TO_LAST) begin
            state_nxt_s = retry_full_s ? ST_FAIL : ST_ASSERT;
            retry_nxt_s = retry_full_s ? retry_r : (retry_r + 2'd1);
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_SETTLE: begin
          if (!locked_s) begin
            state_nxt_s = retry_full_s ? ST_FAIL : ST_ASSERT;
            retry_nxt_s = retry_full_s ? retry_r : (retry_r + 2'd1);
            cnt_nxt_s   = CNT_ZERO;
          end else if (cnt_r == STABLE_LAST) begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_nxt_s     = ST_ASSERT;
            retry_nxt_s     = 2'd0;
            lock_lost_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_RUN;
          end
          cnt_nxt_s = CNT_ZERO;
        end
        ST_FAIL: begin
          state_nxt_s = ST_FAIL;
          cnt_nxt_s   = CNT_ZERO;
        end
        default: begin
          state_nxt_s = ST_ASSERT;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_ASSERT;
      state_par_r <= 1'b0;
      cnt_r       <= CNT_ZERO;
      retry_r     <= 2'd0;
      pll_rst_r   <= 1'b1;
      clk_ready_r <= 1'b0;
      fail_r      <= 1'b0;
      lock_lost_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      state_par_r <= state_parity(state_nxt_s);
      cnt_r       <= cnt_nxt_s;
      retry_r     <= retry_nxt_s;
      pll_rst_r   <= (state_nxt_s == ST_ASSERT) || (state_nxt_s == ST_FAIL);
      clk_ready_r <= (state_nxt_s == ST_RUN);
      fail_r      <= (state_nxt_s == ST_FAIL);
      lock_lost_r <= lock_lost_nxt_s;
    end
  end

  assign pll_rst   = pll_rst_r;
  assign clk_ready = clk_ready_r;
  assign fail      = fail_r;
  assign retry_cnt = retry_r;
  assign lock_lost = lock_lost_r;
  assign state     = state_r;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with RST=4, TIMEOUT=32, STABLE=8, MAX_RETRY=2.
module tb_pll_lock_sequencer;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       force_rst;
  logic       pll_rst;
  logic       clk_ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic       lock_lost;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  pll_lock_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8),
    .MAX_RETRY    (2)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .force_rst (force_rst),
    .pll_rst   (pll_rst),
    .clk_ready (clk_ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .lock_lost (lock_lost),
    .state     (state)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"},     32'(state),     32'd0);
    check({tag, "_pll_rst"},   32'(pll_rst),   32'd1);
    check({tag, "_clk_ready"}, 32'(clk_ready), 32'd0);
    check({tag, "_fail"},      32'(fail),      32'd0);
    check({tag, "_retry"},     32'(retry_cnt), 32'd0);
    check({tag, "_lock_lost"}, 32'(lock_lost), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b1;
    pll_locked = 1'b0;
    force_rst  = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset("por");
    step(2);
    check_reset("por_held");
    rst_n = 1'b1;

    // Nominal lock
    check("nom_rst_c0", 32'(pll_rst), 32'd1);
    step(3);
    check("nom_assert_c3", 32'(state), 32'd0);
    check("nom_rst_c3", 32'(pll_rst), 32'd1);
    step(1);
    check("nom_wait", 32'(state), 32'd1);
    check("nom_rst_off", 32'(pll_rst), 32'd0);
    pll_locked = 1'b1;
    step(2);
    check("nom_sync_lat", 32'(state), 32'd1);
    step(1);
    check("nom_settle", 32'(state), 32'd2);
    step(8);
    check("nom_settle_end", 32'(state), 32'd2);
    check("nom_not_ready", 32'(clk_ready), 32'd0);
    step(1);
    check("nom_run", 32'(state), 32'd3);
    check("nom_ready", 32'(clk_ready), 32'd1);
    check("nom_fail", 32'(fail), 32'd0);
    check("nom_retry", 32'(retry_cnt), 32'd0);

    // Lock loss in RUN, then a one-cycle glitch in SETTLE
    pll_locked = 1'b0;
    step(2);
    check("ll0_still_run", 32'(state), 32'd3);
    check("ll0_no_pulse", 32'(lock_lost), 32'd0);
    step(1);
    check("ll0_state", 32'(state), 32'd0);
    check("ll0_pulse", 32'(lock_lost), 32'd1);
    check("ll0_ready", 32'(clk_ready), 32'd0);
    step(1);
    check("ll0_pulse_end", 32'(lock_lost), 32'd0);
    step(2);
    check("ll0_assert_c3", 32'(state), 32'd0);
    step(1);
    check("ll0_wait", 32'(state), 32'd1);
    pll_locked = 1'b1;
    step(3);
    check("gl_settle", 32'(state), 32'd2);
    step(4);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(1);
    check("gl_pre_state", 32'(state), 32'd2);
    check("gl_pre_retry", 32'(retry_cnt), 32'd0);
    step(1);
    check("gl_state", 32'(state), 32'd0);
    check("gl_retry", 32'(retry_cnt), 32'd1);
    check("gl_pll_rst", 32'(pll_rst), 32'd1);
    step(4);
    check("gl_wait", 32'(state), 32'd1);
    step(1);
    check("gl_settle2", 32'(state), 32'd2);
    step(8);
    check("gl_settle2_end", 32'(state), 32'd2);
    step(1);
    check("gl_run", 32'(state), 32'd3);
    check("gl_run_retry", 32'(retry_cnt), 32'd1);
    check("gl_run_ready", 32'(clk_ready), 32'd1);

    // Lock loss with retry_cnt=1
    pll_locked = 1'b0;
    step(3);
    check("ll1_state", 32'(state), 32'd0);
    check("ll1_pulse", 32'(lock_lost), 32'd1);
    check("ll1_ready", 32'(clk_ready), 32'd0);
    check("ll1_retry", 32'(retry_cnt), 32'd0);
    check("ll1_rst", 32'(pll_rst), 32'd1);
    step(1);
    check("ll1_pulse_end", 32'(lock_lost), 32'd0);
    step(2);
    check("ll1_rst_c3", 32'(pll_rst), 32'd1);
    step(1);
    check("ll1_wait", 32'(state), 32'd1);
    check("ll1_rst_off", 32'(pll_rst), 32'd0);

    // Never locks: three attempts then FAIL
    step(31);
    check("nl_wait_a0", 32'(state), 32'd1);
    step(1);
    check("nl_assert_a1", 32'(state), 32'd0);
    check("nl_retry1", 32'(retry_cnt), 32'd1);
    step(3);
    check("nl_assert_a1_c3", 32'(state), 32'd0);
    step(1);
    check("nl_wait_a1", 32'(state), 32'd1);
    step(31);
    check("nl_wait_a1_end", 32'(state), 32'd1);
    check("nl_retry1_hold", 32'(retry_cnt), 32'd1);
    step(1);
    check("nl_assert_a2", 32'(state), 32'd0);
    check("nl_retry2", 32'(retry_cnt), 32'd2);
    step(4);
    check("nl_wait_a2", 32'(state), 32'd1);
    step(31);
    check("nl_wait_a2_end", 32'(state), 32'd1);
    step(1);
    check("nl_fail_state", 32'(state), 32'd4);
    check("nl_fail", 32'(fail), 32'd1);
    check("nl_fail_rst", 32'(pll_rst), 32'd1);
    check("nl_fail_retry", 32'(retry_cnt), 32'd2);
    check("nl_fail_ready", 32'(clk_ready), 32'd0);
    step(20);
    check("nl_fail_hold", 32'(state), 32'd4);
    check("nl_fail_hold_f", 32'(fail), 32'd1);

    // Recovery from FAIL via force_rst
    force_rst  = 1'b1;
    pll_locked = 1'b1;
    step(1);
    force_rst = 1'b0;
    check("fr_state", 32'(state), 32'd0);
    check("fr_fail", 32'(fail), 32'd0);
    check("fr_retry", 32'(retry_cnt), 32'd0);
    check("fr_rst", 32'(pll_rst), 32'd1);
    step(4);
    check("fr_wait", 32'(state), 32'd1);
    step(1);
    check("fr_settle", 32'(state), 32'd2);
    step(8);
    check("fr_settle_end", 32'(clk_ready), 32'd0);
    step(1);
    check("fr_run", 32'(state), 32'd3);
    check("fr_ready", 32'(clk_ready), 32'd1);

    // force_rst coinciding with lock loss, then force_rst mid-ASSERT
    pll_locked = 1'b0;
    step(2);
    check("fp_run", 32'(state), 32'd3);
    force_rst = 1'b1;
    step(1);
    force_rst = 1'b0;
    check("fp_state", 32'(state), 32'd0);
    check("fp_no_pulse", 32'(lock_lost), 32'd0);
    check("fp_ready", 32'(clk_ready), 32'd0);
    step(2);
    force_rst = 1'b1;
    step(1);
    force_rst = 1'b0;
    check("fa_state", 32'(state), 32'd0);
    step(3);
    check("fa_full_hold", 32'(state), 32'd0);
    step(1);
    check("fa_wait", 32'(state), 32'd1);

    // Asynchronous reset mid-SETTLE
    pll_locked = 1'b1;
    step(3);
    check("ar_settle", 32'(state), 32'd2);
    step(3);
    check("ar_settle_mid", 32'(state), 32'd2);
    #3 rst_n = 1'b0;
    #1 check_reset("ar");
    check("ar_cnt", 32'(dut.cnt_r), 32'd0);
    check("ar_sync", 32'(dut.sync_r), 32'd0);
    step(1);
    check_reset("ar_held");
    rst_n = 1'b1;
    step(3);
    check("ar_hold_c3", 32'(state), 32'd0);
    check("ar_hold_rst", 32'(pll_rst), 32'd1);
    step(1);
    check("ar_wait", 32'(state), 32'd1);
    step(1);
    check("ar_settle2", 32'(state), 32'd2);
    step(8);
    check("ar_settle2_end", 32'(state), 32'd2);
    step(1);
    check("ar_run", 32'(state), 32'd3);
    check("ar_ready", 32'(clk_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: refclk cycles pll_rst is held high per reset attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4096: cycles allowed in WAIT for lock before an attempt times out.
REQ-003 SHALL have parameter STABLE_CYCLES, default 256: consecutive synchronized-lock cycles required before clk_ready asserts.
REQ-004 SHALL have parameter MAX_RETRY, default 3, range 0..3: retries allowed after the first attempt.
REQ-005 SHALL have port refclk, input, 1: single clock, the PLL reference clock.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port pll_locked, input, 1: PLL locked status, asynchronous to refclk.
REQ-008 SHALL have port force_rst, input, 1: synchronous one-cycle request to restart the sequence.
REQ-009 SHALL have port pll_rst, output, 1: active-high reset driven to the PLL.
REQ-010 SHALL have port clk_ready, output, 1: PLL output clocks are valid and stable.
REQ-011 SHALL have port fail, output, 1: retries exhausted; PLL held in reset.
REQ-012 SHALL have port retry_cnt, output, 2: number of retries consumed.
REQ-013 SHALL have port lock_lost, output, 1: one-cycle pulse on loss of lock in RUN.
REQ-014 SHALL have port state, output, 3: current state encoding (ASSERT=0, WAIT=1, SETTLE=2, RUN=3, FAIL=4).

Function
REQ-015 SHALL synchronize pll_locked through two refclk flops into locked_s; all decisions use locked_s only.
REQ-016 SHALL register all outputs; outputs SHALL change only on refclk rising edge, except on rst_n assertion.
REQ-017 SHALL use one shared cycle counter sized to the largest of RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES, cleared on every state entry.
REQ-018 ASSERT: pll_rst=1, clk_ready=0; after exactly RST_CYCLES cycles in ASSERT SHALL enter WAIT.
REQ-019 WAIT: pll_rst=0; locked_s=1 SHALL enter SETTLE next cycle; LOCK_TIMEOUT cycles without locked_s SHALL raise a timeout event.
REQ-020 SETTLE: pll_rst=0; after STABLE_CYCLES consecutive cycles with locked_s=1 SHALL enter RUN; any locked_s=0 cycle SHALL raise a timeout event.
REQ-021 On a timeout event: if retry_cnt==MAX_RETRY SHALL enter FAIL; else SHALL increment retry_cnt and enter ASSERT.
REQ-022 RUN: clk_ready=1, pll_rst=0; locked_s=0 SHALL pulse lock_lost for one cycle, clear clk_ready, clear retry_cnt and enter ASSERT, all on the same edge.
REQ-023 FAIL: pll_rst=1, fail=1, clk_ready=0; SHALL remain until force_rst or rst_n.
REQ-024 force_rst=1 SHALL, from any state, enter ASSERT next edge with retry_cnt=0, fail=0, clk_ready=0, and no lock_lost pulse; it SHALL take priority over every other transition.
REQ-025 retry_cnt SHALL never exceed MAX_RETRY; it SHALL be cleared only by rst_n, force_rst or lock loss in RUN.
REQ-026 Nominal latency: clk_ready SHALL rise STABLE_CYCLES+1 edges after the edge on which locked_s is first seen high in WAIT.

Reset
REQ-027 rst_n=0 SHALL immediately force state=ASSERT, pll_rst=1, clk_ready=0, fail=0, retry_cnt=0, lock_lost=0, counter=0, synchronizer flops=0.
REQ-028 On rst_n release the sequence SHALL start at ASSERT with a full RST_CYCLES hold, including when asserted mid-WAIT, SETTLE or RUN.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRY=2)
REQ-029 Nominal: release rst_n, pll_locked=1 from the first WAIT cycle -> pll_rst high 4 cycles, state 0->1->2->3, clk_ready=1 with fail=0 and retry_cnt=0.
REQ-030 Never locks: pll_locked=0 -> three ASSERT periods, each followed by 32 WAIT cycles, retry_cnt 0->1->2, then state=4, fail=1, pll_rst=1 held.
REQ-031 Glitch: pll_locked drops for 1 cycle at SETTLE cycle 5 -> retry_cnt=1, state=ASSERT; a stable relock then reaches RUN.
REQ-032 Lock loss: in RUN with retry_cnt=1, drop pll_locked -> lock_lost high exactly 1 cycle, clk_ready=0, retry_cnt=0, pll_rst high 4 cycles.
REQ-033 Recovery: in FAIL, pulse force_rst -> state=ASSERT next edge, fail=0, retry_cnt=0; with pll_locked=1 the block reaches RUN.
REQ-034 Async reset: assert rst_n mid-SETTLE between clock edges -> all outputs take their REQ-027 values without a clock edge.
